// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, FSM encodings, RCON table and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;
  typedef logic [1:0]   fsm_t;

  localparam fsm_t ST_IDLE  = 2'd0;
  localparam fsm_t ST_ROUND = 2'd1;
  localparam fsm_t ST_DONE  = 2'd2;

  // Round constant for key expansion, indexed by round number 1..10.
  function automatic byte_t rcon(input logic [3:0] rnd);
    byte_t rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product by shift-and-add.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic byte_t sbox(input byte_t x);
    byte_t x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // MixColumns on one column, byte 0 in the top bits.
  function automatic word_t mix_col(input word_t c);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (SubBytes, ShiftRows, MixColumns
// unless last, AddRoundKey). State bytes are column-major, byte 0 = [127:120].
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk_in,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] sb_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  for (genvar c = 0; c < 4; c++) begin : g_sbox
    aes_sbox_word u_sbox_word (
      .in_word  (state_in[127-32*c -: 32]),
      .out_word (sb_s[127-32*c -: 32])
    );
  end

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  always_comb begin
    sr_s = {128{1'b0}};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns on each of the four columns.
  always_comb begin
    mc_s = {128{1'b0}};
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
    end
  end

  // AddRoundKey; the final round bypasses MixColumns.
  always_comb begin
    if (last) state_out = sr_s ^ rk_in;
    else      state_out = mc_s ^ rk_in;
  end

endmodule

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: four parallel S-box lookups on one 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  assign out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                     sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// aes_enc_round_ctrl: iterative AES-128 encryption sequencer with on-the-fly
// round-key generation and valid/ready handshakes on both sides.
// Optional feature macro: AES_CTRL_BACK_TO_BACK_EN (accept a new block on the
// same edge the previous result drains).
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS   = 10,
  parameter bit CLR_ON_DRAIN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NUM_ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_enc_round_ctrl: only NUM_ROUNDS = 10 is supported");
  end

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] cipher_q, cipher_d;

  logic         in_ready_s;
  logic [31:0]  rot_s, sub_s;
  logic [31:0]  kw0_s, kw1_s, kw2_s, kw3_s;
  logic [127:0] next_rk_s;
  logic [127:0] round_out_s;

  // Key step: RotWord of the last word, SubWord, RCON into the top byte, cascaded XOR.
  assign rot_s = {rk_q[23:0], rk_q[31:24]};

  aes_sbox_word u_key_sbox (
    .in_word  (rot_s),
    .out_word (sub_s)
  );

  assign kw0_s     = rk_q[127:96] ^ sub_s ^ {rcon(rnd_q), 24'h000000};
  assign kw1_s     = rk_q[95:64] ^ kw0_s;
  assign kw2_s     = rk_q[63:32] ^ kw1_s;
  assign kw3_s     = rk_q[31:0]  ^ kw2_s;
  assign next_rk_s = {kw0_s, kw1_s, kw2_s, kw3_s};

  aes_round u_round (
    .state_in  (st_q),
    .rk_in     (next_rk_s),
    .last      (rnd_q == 4'd10),
    .state_out (round_out_s)
  );

  // Input acceptance: IDLE always, DONE only while draining when back-to-back is built in.
  always_comb begin
    in_ready_s = 1'b0;
    if (!reset) begin
      in_ready_s = 1'b0;
    end else if (fsm_q == ST_IDLE) begin
      in_ready_s = 1'b1;
`ifdef AES_CTRL_BACK_TO_BACK_EN
    end else if (fsm_q == ST_DONE) begin
      in_ready_s = out_ready;
`endif
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    cipher_d    = cipher_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready_s) begin
          st_d  = data_in ^ key;
          rk_d  = key;
          rnd_d = 4'd1;
          fsm_d = ST_ROUND;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        st_d = round_out_s;
        rk_d = next_rk_s;
        if (rnd_q == 4'd10) begin
          cipher_d    = round_out_s;
          out_valid_d = 1'b1;
          fsm_d       = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (CLR_ON_DRAIN) cipher_d = 128'h0;
          else              cipher_d = cipher_q;
`ifdef AES_CTRL_BACK_TO_BACK_EN
          if (in_valid && in_ready_s) begin
            st_d  = data_in ^ key;
            rk_d  = key;
            rnd_d = 4'd1;
            fsm_d = ST_ROUND;
          end else begin
            rnd_d = 4'd0;
            fsm_d = ST_IDLE;
          end
`else
          rnd_d = 4'd0;
          fsm_d = ST_IDLE;
`endif
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= ST_IDLE;
      st_q        <= 128'h0;
      rk_q        <= 128'h0;
      rnd_q       <= 4'd0;
      out_valid_q <= 1'b0;
      cipher_q    <= 128'h0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      cipher_q    <= cipher_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign cipher    = cipher_q;
  assign busy      = (fsm_q == ST_ROUND);
  assign round_idx = rnd_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// tb_aes_enc_round_ctrl: directed FIPS-197 vectors plus randomized traffic,
// checked every cycle against a block-level behavioural model.
module tb_aes_enc_round_ctrl;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CTRL_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] data_in = 128'h0;
  logic [127:0] key = 128'h0;
  logic in_ready, out_valid, busy;
  logic [127:0] cipher;
  logic [3:0] round_idx;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_enc_round_ctrl #(.NUM_ROUNDS(10), .CLR_ON_DRAIN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .cipher(cipher), .busy(busy), .round_idx(round_idx)
  );

  task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Whole-block AES-128 encryption on byte arrays.
  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sb[w[13]] ^ rc;
      tmp[1] = sb[w[14]];
      tmp[2] = sb[w[15]];
      tmp[3] = sb[w[12]];
      for (int i = 0; i < 16; i++) begin
        if (i < 4) w[i] = w[i] ^ tmp[i];
        else       w[i] = w[i] ^ w[i-4];
      end
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sb[s[4*((c+rr)%4)+rr]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Block-level model: a job runs for rounds 1..10, then its result waits for a drain.
  bit m_run = 1'b0;
  bit m_valid = 1'b0;
  int m_rnd = 0;
  logic [127:0] m_cipher = 128'h0;
  logic [127:0] m_res = 128'h0;
  logic exp_in_ready;
  assign exp_in_ready = reset && !m_run && (!m_valid || (B2B && out_ready));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_run <= 1'b0; m_valid <= 1'b0; m_rnd <= 0; m_cipher <= 128'h0;
    end else begin
      if (m_run) begin
        if (m_rnd == 10) begin
          m_run <= 1'b0; m_valid <= 1'b1; m_cipher <= m_res;
        end else begin
          m_rnd <= m_rnd + 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0; m_cipher <= 128'h0; m_rnd <= 0;
      end
      if (in_valid && exp_in_ready) begin
        m_run <= 1'b1; m_rnd <= 1; m_res <= ref_aes(data_in, key);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("in_ready", in_ready, exp_in_ready);
      check1("out_valid", out_valid, m_valid);
      check1("busy", busy, m_run);
      check_int("round_idx", int'(round_idx), m_rnd);
      check128("cipher", cipher, m_cipher);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, t1, t2;

  initial begin
    build_sbox();
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check128("rst_cipher", cipher, 128'h0);
    check_int("rst_round_idx", int'(round_idx), 0);
    check128("ref_sbox_53", {120'h0, sb[8'h53]}, 128'hed);
    check128("ref_appB", ref_aes(PT_B, K_B), CT_B);
    check128("ref_appC", ref_aes(PT_C, K_C), CT_C);
    reset = 1'b1;
    tick();

    // App. B: latency, round-1 key, inputs changed mid-round, backpressure.
    check1("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; data_in = PT_B; key = K_B;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (round_idx == 4'd2) check128("rk_round1", dut.rk_q, RK1_B);
      if (round_idx == 4'd5) begin data_in = '1; key = '1; in_valid = 1'b1; end
      tick();
      n++;
    end
    check_int("latency_appB", n, 10);
    check128("cipher_appB", cipher, CT_B);
    repeat (20) begin
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    check1("bp_out_valid", out_valid, 1'b1);
    check128("bp_cipher", cipher, CT_B);
    check1("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("drain_out_valid", out_valid, 1'b0);
    check128("drain_cipher", cipher, 128'h0);

    // Reset at round 6, then App. C.1 from clean.
    in_valid = 1'b1; data_in = PT_C; key = K_C;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd6 && n < 40) begin tick(); n++; end
    check_int("reach_round6", int'(round_idx), 6);
    reset = 1'b0;
    tick();
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check_int("midrst_round_idx", int'(round_idx), 0);
    reset = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check_int("latency_appC", n, 10);
    check128("cipher_appC", cipher, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Two blocks with in_valid/out_ready held high: spacing of the results.
    in_valid = 1'b1; out_ready = 1'b1; data_in = PT_B; key = K_B;
    tick();
    data_in = PT_C; key = K_C;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    t1 = cyc;
    check128("tp_first", cipher, CT_B);
    tick();
    n = 0;
    while (!busy && n < 5) begin tick(); n++; end
    check1("tp_second_busy", busy, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    t2 = cyc;
    check_int("tp_spacing", t2 - t1, B2B ? 11 : 12);
    check128("tp_second", cipher, CT_C);
    tick();
    out_ready = 1'b0;

    // Randomized traffic, occasional resets.
    repeat (600) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) tick();
    check1("final_idle", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_enc_round_ctrl.md
Name: aes_enc_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer. It owns the 128-bit state register and the running round-key register, and steps one shared single-round datapath through rounds 1..10.
- It computes the next round key on the fly from the current round key, so no full key schedule is stored.
- Upstream and downstream are valid/ready handshakes. The block sits between the host-side block buffer and the cipher output path of the encryption top.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal, any other value is an elaboration error.
- CLR_ON_DRAIN, 1, when 1 the cipher output register is cleared to 0 when the output handshake completes.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  block can accept a pair this cycle.
- data_in  in  128  plaintext, FIPS-197 byte order (byte 0 = [127:120]).
- key  in  128  cipher key, same byte order.
- out_valid  out  1  cipher holds a completed result.
- out_ready  in  1  consumer accepts the result.
- cipher  out  128  ciphertext.
- busy  out  1  high while in ROUND state.
- round_idx  out  4  current round number, 0 when idle, 1..10 during rounds.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE.
  - out_valid=0, cipher=0, busy=0, round_idx=0; state and round-key registers are cleared to 0.
  - in_ready is held 0 while reset is low.
  - Reset during ROUND or DONE abandons the block; no partial result is ever presented.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&in_ready: state<=data_in^key, rk<=key, rnd<=1, go to ROUND.
  - ROUND: busy=1, in_ready=0.
    - next_rk = key_step(rk, RCON[rnd]): rotate the last word, apply sbox, XOR RCON into the top byte, then the cascaded XOR.
    - state <= round(state, next_rk, last=(rnd==10)); rk<=next_rk; rnd<=rnd+1.
    - On rnd==10: cipher <= the round result, out_valid<=1, go to DONE.
  - DONE: out_valid=1, cipher stable. When out_ready: out_valid<=0 (cipher cleared if CLR_ON_DRAIN), go to IDLE.
- Round function: SubBytes, ShiftRows (row r rotated left by r), MixColumns skipped when last=1, then AddRoundKey.
- Latency: if the input handshake occurs at edge k, out_valid is high from edge k+10. Throughput is one block per 12 cycles, or 11 with the optional feature.
- Input handling:
  - in_valid while not in_ready is ignored; data_in and key are sampled only at the handshake edge.
  - Input changes during ROUND have no effect.
- out_ready while out_valid=0 is ignored.
- round_idx counts 1..10 and never wraps past 10.
- RCON sequence: 01,02,04,08,10,20,40,80,1B,36.

Optional Feature:
- Macro: AES_CTRL_BACK_TO_BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - A simultaneous output drain and input accept loads the new block and moves directly to ROUND with rnd=1.
  - out_valid drops that edge, so there is no idle bubble.
- Undefined: in_ready is high only in IDLE, which costs a one-cycle bubble per block.

Decomposition:
- aes_pkg holds:
  - the RCON table;
  - the AES_ROUNDS=10 constant;
  - the FSM state enum (IDLE, ROUND, DONE);
  - the byte/word/state typedefs;
  - the GF(2^8) xtime function.
- One sub-module, aes_round: purely combinational, inputs state_in, rk_in and last; output state_out. It instantiates 4 existing sbox word instances.
- The controller instantiates one further sbox word instance for key_step.

Test Plan:
- FIPS-197 App. B: data_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> cipher=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept; the round-1 internal rk equals a0fafe1788542cb123a339392a6c7605.
- FIPS-197 App. C.1: data_in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> cipher=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and cipher stable, in_ready=0; a new in_valid is ignored; after out_ready=1 for one cycle -> out_valid=0, cipher=0 with CLR_ON_DRAIN=1.
- Input change mid-round: at round_idx=5, change data_in/key to all-ones -> the App. B result is unchanged.
- Reset mid-operation: reset=0 at round_idx=6 -> next edge out_valid=0, busy=0, round_idx=0; after release the App. C.1 vector completes correctly.
- Back-to-back (macro defined): in_valid and out_ready held high with two vectors -> second accept on the same edge as the first drain; the second cipher appears 11 edges after the first.
